// File: rtl/ex_stage.sv
// Execute stage of a five-stage RV32 pipeline: operand forwarding, ALU,
// branch resolution (combinational redirect) and the EX/MEM pipeline register.
module ex_stage #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            flush_and_stall,

    // ID/EX pipeline register contents
    input  logic                  MemtoReg,
    input  logic                  RegWrite,
    input  logic                  MemWrite,
    input  logic                  MemRead,
    input  logic                  MemSize,
    input  logic [2:0]            Branch,
    input  logic [3:0]            ALUOp,
    input  logic [1:0]            ALUSrc,
    input  logic [ADDR_WIDTH-1:0] PC,
    input  logic [DATA_WIDTH-1:0] rs1_data,
    input  logic [DATA_WIDTH-1:0] rs2_data,
    input  logic [DATA_WIDTH-1:0] imm,
    input  logic [4:0]            rs1_addr,
    input  logic [4:0]            rs2_addr,
    input  logic [4:0]            rd_addr,

    // MEM/WB write-back path, used as the second forwarding source
    input  logic                  wb_RegWrite,
    input  logic [4:0]            wb_rd,
    input  logic [DATA_WIDTH-1:0] wb_data,

    // EX/MEM pipeline register
    output logic                  MemtoReg_out,
    output logic                  RegWrite_out,
    output logic                  MemWrite_out,
    output logic                  MemRead_out,
    output logic                  MemSize_out,
    output logic [DATA_WIDTH-1:0] alu_result_out,
    output logic [DATA_WIDTH-1:0] store_data_out,
    output logic [4:0]            rd_addr_out,

    // Redirect to fetch, resolved in this cycle
    output logic                  branch_taken,
    output logic [ADDR_WIDTH-1:0] branch_target
);

    logic stall;
    logic flush;
    assign stall = flush_and_stall[0];
    assign flush = flush_and_stall[1];

    // EX/MEM state
    logic                  memtoreg_q, memtoreg_d;
    logic                  regwrite_q, regwrite_d;
    logic                  memwrite_q, memwrite_d;
    logic                  memread_q,  memread_d;
    logic                  memsize_q,  memsize_d;
    logic [DATA_WIDTH-1:0] alu_q,      alu_d;
    logic [DATA_WIDTH-1:0] store_q,    store_d;
    logic [4:0]            rd_q,       rd_d;

    logic [DATA_WIDTH-1:0] fwd_a;
    logic [DATA_WIDTH-1:0] fwd_b;
    logic [DATA_WIDTH-1:0] alu_a;
    logic [DATA_WIDTH-1:0] alu_b;
    logic [DATA_WIDTH-1:0] alu_res;
    logic [4:0]            shamt;
    logic [DATA_WIDTH-1:0] jalr_sum;
    logic                  cond;

    // Forwarding muxes. A load sitting in EX/MEM has no data yet, so it is
    // skipped and the hazard unit is relied on to have stalled.
    always_comb begin
        fwd_a = rs1_data;
        if (rs1_addr != 5'd0 && regwrite_q && !memread_q && rd_q == rs1_addr)
            fwd_a = alu_q;
        else if (wb_RegWrite && wb_rd == rs1_addr && rs1_addr != 5'd0)
            fwd_a = wb_data;

        fwd_b = rs2_data;
        if (rs2_addr != 5'd0 && regwrite_q && !memread_q && rd_q == rs2_addr)
            fwd_b = alu_q;
        else if (wb_RegWrite && wb_rd == rs2_addr && rs2_addr != 5'd0)
            fwd_b = wb_data;
    end

    // ALU operand selection (PC-relative forms for AUIPC/JAL/JALR link)
    always_comb begin
        alu_a = fwd_a;
        alu_b = fwd_b;
        case (ALUSrc)
            2'b00: begin alu_a = fwd_a;              alu_b = fwd_b;            end
            2'b01: begin alu_a = fwd_a;              alu_b = imm;              end
            2'b10: begin alu_a = DATA_WIDTH'(PC);    alu_b = imm;              end
            2'b11: begin alu_a = DATA_WIDTH'(PC);    alu_b = DATA_WIDTH'(4);   end
            default: ;
        endcase
    end

    assign shamt = alu_b[4:0];

    // ALU; unused opcodes yield zero
    always_comb begin
        alu_res = '0;
        case (ALUOp)
            4'd0:  alu_res = alu_a + alu_b;
            4'd1:  alu_res = alu_a - alu_b;
            4'd2:  alu_res = alu_a & alu_b;
            4'd3:  alu_res = alu_a | alu_b;
            4'd4:  alu_res = alu_a ^ alu_b;
            4'd5:  alu_res = alu_a << shamt;
            4'd6:  alu_res = alu_a >> shamt;
            4'd7:  alu_res = $signed(alu_a) >>> shamt;
            4'd8:  alu_res = {{(DATA_WIDTH-1){1'b0}}, $signed(alu_a) < $signed(alu_b)};
            4'd9:  alu_res = {{(DATA_WIDTH-1){1'b0}}, alu_a < alu_b};
            4'd10: alu_res = alu_b;
            default: alu_res = '0;
        endcase
    end

    // Branch condition on forwarded register values; suppressed while the
    // stage is frozen or being squashed so fetch is not redirected twice.
    always_comb begin
        cond = 1'b0;
        case (Branch)
            3'b001: cond = (fwd_a == fwd_b);
            3'b010: cond = (fwd_a != fwd_b);
            3'b011: cond = ($signed(fwd_a) <  $signed(fwd_b));
            3'b100: cond = ($signed(fwd_a) >= $signed(fwd_b));
            3'b101: cond = (fwd_a <  fwd_b);
            3'b110: cond = (fwd_a >= fwd_b);
            3'b111: cond = 1'b1;
            default: cond = 1'b0;
        endcase
        branch_taken = cond && !stall && !flush;
    end

    assign jalr_sum = fwd_a + imm;

    // Target: PC-relative for conditional branches, register-relative for JALR
    always_comb begin
        branch_target = PC + ADDR_WIDTH'(imm);
        if (Branch == 3'b111)
            branch_target = {jalr_sum[ADDR_WIDTH-1:1], 1'b0};
    end

    // EX/MEM next state: flush beats stall, stall holds, otherwise load
    always_comb begin
        memtoreg_d = memtoreg_q;
        regwrite_d = regwrite_q;
        memwrite_d = memwrite_q;
        memread_d  = memread_q;
        memsize_d  = memsize_q;
        alu_d      = alu_q;
        store_d    = store_q;
        rd_d       = rd_q;
        if (flush) begin
            memtoreg_d = 1'b0;
            regwrite_d = 1'b0;
            memwrite_d = 1'b0;
            memread_d  = 1'b0;
            memsize_d  = 1'b1;
            alu_d      = '0;
            store_d    = '0;
            rd_d       = 5'd0;
        end else if (!stall) begin
            memtoreg_d = MemtoReg;
            regwrite_d = RegWrite;
            memwrite_d = MemWrite;
            memread_d  = MemRead;
            memsize_d  = MemSize;
            alu_d      = alu_res;
            store_d    = fwd_b;
            rd_d       = rd_addr;
        end
    end

    // EX/MEM register with asynchronous reset to a bubble (word-sized)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            memtoreg_q <= 1'b0;
            regwrite_q <= 1'b0;
            memwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            memsize_q  <= 1'b1;
            alu_q      <= '0;
            store_q    <= '0;
            rd_q       <= 5'd0;
        end else begin
            memtoreg_q <= memtoreg_d;
            regwrite_q <= regwrite_d;
            memwrite_q <= memwrite_d;
            memread_q  <= memread_d;
            memsize_q  <= memsize_d;
            alu_q      <= alu_d;
            store_q    <= store_d;
            rd_q       <= rd_d;
        end
    end

    assign MemtoReg_out   = memtoreg_q;
    assign RegWrite_out   = regwrite_q;
    assign MemWrite_out   = memwrite_q;
    assign MemRead_out    = memread_q;
    assign MemSize_out    = memsize_q;
    assign alu_result_out = alu_q;
    assign store_data_out = store_q;
    assign rd_addr_out    = rd_q;

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: ALU vector table, hand-written forwarding / branch /
// stall / flush / reset sequences, then random traffic against a model.
module tb_ex_stage;

    logic        clk;
    logic        reset;
    logic [1:0]  flush_and_stall;
    logic        MemtoReg, RegWrite, MemWrite, MemRead, MemSize;
    logic [2:0]  Branch;
    logic [3:0]  ALUOp;
    logic [1:0]  ALUSrc;
    logic [31:0] PC, rs1_data, rs2_data, imm;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic        wb_RegWrite;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        MemtoReg_out, RegWrite_out, MemWrite_out, MemRead_out, MemSize_out;
    logic [31:0] alu_result_out, store_data_out;
    logic [4:0]  rd_addr_out;
    logic        branch_taken;
    logic [31:0] branch_target;

    int tests = 0;
    int fails = 0;

    ex_stage #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .flush_and_stall(flush_and_stall),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .MemWrite(MemWrite),
        .MemRead(MemRead), .MemSize(MemSize), .Branch(Branch), .ALUOp(ALUOp),
        .ALUSrc(ALUSrc), .PC(PC), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .imm(imm), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
        .wb_RegWrite(wb_RegWrite), .wb_rd(wb_rd), .wb_data(wb_data),
        .MemtoReg_out(MemtoReg_out), .RegWrite_out(RegWrite_out),
        .MemWrite_out(MemWrite_out), .MemRead_out(MemRead_out),
        .MemSize_out(MemSize_out), .alu_result_out(alu_result_out),
        .store_data_out(store_data_out), .rd_addr_out(rd_addr_out),
        .branch_taken(branch_taken), .branch_target(branch_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        logic        memtoreg, regwrite, memwrite, memread, memsize;
        logic [31:0] alu, store;
        logic [4:0]  rd;
    } exm_t;

    exm_t m;

    function automatic exm_t bubble();
        exm_t b;
        b.memtoreg = 0; b.regwrite = 0; b.memwrite = 0; b.memread = 0;
        b.memsize = 1; b.alu = 0; b.store = 0; b.rd = 0;
        return b;
    endfunction

    // Newest producer wins; loads still in EX/MEM have no value to give.
    function automatic logic [31:0] m_fwd(logic [4:0] a, logic [31:0] raw);
        if (a == 0) return raw;
        if (m.regwrite && !m.memread && m.rd == a) return m.alu;
        if (wb_RegWrite && wb_rd == a) return wb_data;
        return raw;
    endfunction

    function automatic logic [31:0] m_alu(logic [3:0] op, logic [31:0] a, logic [31:0] b);
        int unsigned s;
        logic [31:0] r;
        s = b % 32;
        case (op)
            0:  return a + b;
            1:  return a + (~b + 1);
            2:  return a & b;
            3:  return a | b;
            4:  return a ^ b;
            5:  return a * (32'd1 << s);
            6:  return a / (32'd1 << s);
            7:  begin
                    r = a / (32'd1 << s);
                    if (a[31] && s != 0) r = r | ~(32'hFFFF_FFFF >> s);
                    return r;
                end
            8:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            9:  return (a < b) ? 32'd1 : 32'd0;
            10: return b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic m_cond(logic [2:0] br, logic [31:0] a, logic [31:0] b);
        case (br)
            1: return a == b;
            2: return a != b;
            3: return int'(a) <  int'(b);
            4: return int'(a) >= int'(b);
            5: return a < b;
            6: return a >= b;
            7: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_regs(string tag);
        chk({tag, ".MemtoReg_out"},   32'(MemtoReg_out), 32'(m.memtoreg));
        chk({tag, ".RegWrite_out"},   32'(RegWrite_out), 32'(m.regwrite));
        chk({tag, ".MemWrite_out"},   32'(MemWrite_out), 32'(m.memwrite));
        chk({tag, ".MemRead_out"},    32'(MemRead_out),  32'(m.memread));
        chk({tag, ".MemSize_out"},    32'(MemSize_out),  32'(m.memsize));
        chk({tag, ".alu_result_out"}, alu_result_out,    m.alu);
        chk({tag, ".store_data_out"}, store_data_out,    m.store);
        chk({tag, ".rd_addr_out"},    32'(rd_addr_out),  32'(m.rd));
    endtask

    // Inputs already driven; check the redirect, clock once, check EX/MEM.
    task automatic step(string tag);
        logic [31:0] fa, fb, a, b, tgt;
        logic        tk;
        exm_t        nx;
        fa = m_fwd(rs1_addr, rs1_data);
        fb = m_fwd(rs2_addr, rs2_data);
        a  = ALUSrc[1] ? PC : fa;
        b  = (ALUSrc == 2'b00) ? fb : (ALUSrc == 2'b11) ? 32'd4 : imm;
        tk = m_cond(Branch, fa, fb) && flush_and_stall == 2'b00 && !reset;
        tgt = (Branch == 3'b111) ? ((fa + imm) & ~32'd1) : (PC + imm);
        chk({tag, ".branch_taken"}, 32'(branch_taken), 32'(tk));
        if (Branch != 3'b000) chk({tag, ".branch_target"}, branch_target, tgt);
        nx.memtoreg = MemtoReg; nx.regwrite = RegWrite; nx.memwrite = MemWrite;
        nx.memread = MemRead; nx.memsize = MemSize;
        nx.alu = m_alu(ALUOp, a, b); nx.store = fb; nx.rd = rd_addr;
        @(posedge clk);
        if (reset) m = bubble();
        else if (flush_and_stall[1]) m = bubble();
        else if (!flush_and_stall[0]) m = nx;
        @(negedge clk);
        check_regs(tag);
        $display("[TB] txn %s fs=%b alu=%h st=%h rd=%0d", tag, flush_and_stall,
                 alu_result_out, store_data_out, rd_addr_out);
    endtask

    task automatic idle_inputs();
        flush_and_stall = 0; MemtoReg = 0; RegWrite = 0; MemWrite = 0; MemRead = 0;
        MemSize = 0; Branch = 0; ALUOp = 0; ALUSrc = 0; PC = 0; rs1_data = 0;
        rs2_data = 0; imm = 0; rs1_addr = 0; rs2_addr = 0; rd_addr = 0;
        wb_RegWrite = 0; wb_rd = 0; wb_data = 0;
    endtask

    // ALU vectors (register addresses 0, so operands are raw data)
    typedef struct {
        logic [3:0]  op;
        logic [1:0]  src;
        logic [31:0] a, b, imm, pc, exp;
    } vec_t;

    vec_t vt [16];

    initial begin
        vt[0]  = '{4'd0,  2'b00, 32'd5,         32'd7,         32'd0,         32'd0,     32'd12};
        vt[1]  = '{4'd1,  2'b00, 32'd3,         32'd5,         32'd0,         32'd0,     32'hFFFF_FFFE};
        vt[2]  = '{4'd2,  2'b00, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0,         32'd0,     32'hF000_F000};
        vt[3]  = '{4'd3,  2'b00, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0,         32'd0,     32'hFFF0_FFF0};
        vt[4]  = '{4'd4,  2'b00, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0,         32'd0,     32'h0FF0_0FF0};
        vt[5]  = '{4'd5,  2'b00, 32'd1,         32'd31,        32'd0,         32'd0,     32'h8000_0000};
        vt[6]  = '{4'd5,  2'b00, 32'd1,         32'd33,        32'd0,         32'd0,     32'd2};
        vt[7]  = '{4'd6,  2'b00, 32'h8000_0000, 32'd4,         32'd0,         32'd0,     32'h0800_0000};
        vt[8]  = '{4'd7,  2'b00, 32'h8000_0000, 32'd4,         32'd0,         32'd0,     32'hF800_0000};
        vt[9]  = '{4'd8,  2'b00, 32'hFFFF_FFFF, 32'd1,         32'd0,         32'd0,     32'd1};
        vt[10] = '{4'd9,  2'b00, 32'hFFFF_FFFF, 32'd1,         32'd0,         32'd0,     32'd0};
        vt[11] = '{4'd10, 2'b01, 32'd9,         32'd8,         32'h1234_ABCD, 32'd0,     32'h1234_ABCD};
        vt[12] = '{4'd13, 2'b00, 32'd5,         32'd7,         32'd0,         32'd0,     32'd0};
        vt[13] = '{4'd0,  2'b10, 32'd9,         32'd8,         32'h20,        32'h100,   32'h120};
        vt[14] = '{4'd0,  2'b11, 32'd9,         32'd8,         32'h20,        32'h100,   32'h104};
        vt[15] = '{4'd1,  2'b01, 32'd10,        32'd8,         32'd3,         32'd0,     32'd7};

        idle_inputs();
        reset = 1'b1;
        m = bubble();

        // Reset state (also: no redirect while the ID/EX controls are zero)
        @(negedge clk); @(negedge clk);
        check_regs("reset");
        chk("reset.branch_taken", 32'(branch_taken), 32'd0);
        reset = 1'b0;

        // ALU table
        for (int i = 0; i < 16; i++) begin
            ALUOp = vt[i].op; ALUSrc = vt[i].src; rs1_data = vt[i].a;
            rs2_data = vt[i].b; imm = vt[i].imm; PC = vt[i].pc;
            RegWrite = 1; rd_addr = 5'd10;
            #1;
            step($sformatf("vec%0d", i));
            chk($sformatf("vec%0d.result", i), alu_result_out, vt[i].exp);
        end

        // EX/MEM forwarding of a just-computed ADDI x1=5
        idle_inputs();
        ALUSrc = 2'b01; imm = 5; rd_addr = 1; RegWrite = 1;
        #1; step("addi_x1");
        ALUSrc = 2'b00; imm = 0; rs1_addr = 1; rs1_data = 0; rs2_addr = 2;
        rs2_data = 7; rd_addr = 3;
        #1; step("add_x3");
        chk("fwd_exmem.result", alu_result_out, 32'd12);

        // Both stages target x2: EX/MEM wins
        idle_inputs();
        ALUSrc = 2'b01; imm = 32'h11; rd_addr = 2; RegWrite = 1;
        #1; step("set_x2");
        ALUSrc = 2'b01; imm = 32'hAB; ALUOp = 4'd0; rs2_addr = 2; rs2_data = 32'h99;
        wb_RegWrite = 1; wb_rd = 2; wb_data = 32'h22; rd_addr = 0; RegWrite = 1;
        #1; step("prio_x2");
        chk("fwd_prio.store", store_data_out, 32'h11);
        // x0 in both stages: raw data
        ALUSrc = 2'b00; ALUOp = 4'd10; imm = 0; rs2_addr = 0; rs2_data = 32'h55;
        wb_rd = 0;
        #1; step("x0_raw");
        chk("fwd_x0.result", alu_result_out, 32'h55);
        // MEM/WB only, and this instruction is a load to x3
        ALUSrc = 2'b01; ALUOp = 4'd0; imm = 32'h40; rs2_addr = 3; rs2_data = 32'h99;
        wb_rd = 3; wb_data = 32'h33; rd_addr = 3; MemRead = 1; MemtoReg = 1;
        #1; step("load_x3");
        chk("fwd_wb.store", store_data_out, 32'h33);
        // Load in EX/MEM is not forwarded
        ALUSrc = 2'b00; ALUOp = 4'd10; wb_data = 32'h77; MemRead = 0; MemtoReg = 0;
        rd_addr = 4;
        #1; step("no_load_fwd");
        chk("fwd_noload.result", alu_result_out, 32'h77);

        // Branches (operands raw via x0-free idle)
        idle_inputs();
        Branch = 3'b011; rs1_data = 32'hFFFF_FFFF; rs2_data = 1; PC = 32'h8000_0010;
        imm = 32'hFFFF_FFF8;
        #1;
        chk("blt.taken", 32'(branch_taken), 32'd1);
        chk("blt.target", branch_target, 32'h8000_0008);
        step("blt");
        Branch = 3'b101;
        #1;
        chk("bltu.taken", 32'(branch_taken), 32'd0);
        step("bltu");
        Branch = 3'b111; rs1_data = 32'h8000_0103; imm = 4; PC = 32'h8000_0000;
        ALUSrc = 2'b11; ALUOp = 0; RegWrite = 1; rd_addr = 1;
        #1;
        chk("jalr.taken", 32'(branch_taken), 32'd1);
        chk("jalr.target", branch_target, 32'h8000_0106);
        step("jalr");
        chk("jalr.link", alu_result_out, 32'h8000_0004);

        // Stall for 3 cycles, then release
        idle_inputs();
        ALUSrc = 2'b01; imm = 32'hAAAA; rd_addr = 7; RegWrite = 1; MemWrite = 1;
        #1; step("pre_stall");
        imm = 32'hBBBB; rd_addr = 9; Branch = 3'b001; flush_and_stall = 2'b01;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall.branch_taken", 32'(branch_taken), 32'd0);
            step($sformatf("stall%0d", i));
            chk("stall.hold", alu_result_out, 32'hAAAA);
        end
        flush_and_stall = 2'b00;
        #1;
        chk("release.branch_taken", 32'(branch_taken), 32'd1);
        step("release");
        chk("release.result", alu_result_out, 32'hBBBB);
        flush_and_stall = 2'b11;
        #1;
        chk("flushstall.branch_taken", 32'(branch_taken), 32'd0);
        step("flush_stall");
        chk("flushstall.memsize", 32'(MemSize_out), 32'd1);
        chk("flushstall.rd", 32'(rd_addr_out), 32'd0);

        // Async reset pulse between edges while stalled
        flush_and_stall = 2'b00; imm = 32'h1357; rd_addr = 4; Branch = 0;
        #1; step("pre_reset");
        idle_inputs();
        flush_and_stall = 2'b01;
        #2 reset = 1'b1;
        #1;
        m = bubble();
        check_regs("async_reset");
        chk("async_reset.branch_taken", 32'(branch_taken), 32'd0);
        #1 reset = 1'b0;
        @(negedge clk);
        check_regs("reset_then_stall");
        flush_and_stall = 2'b00;

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            int unsigned r;
            r = $urandom_range(0, 15);
            flush_and_stall = (r == 0) ? 2'b11 : (r < 3) ? 2'b10 : (r < 6) ? 2'b01 : 2'b00;
            MemtoReg = 1'($urandom); RegWrite = 1'($urandom); MemWrite = 1'($urandom);
            MemRead = ($urandom_range(0, 3) == 0); MemSize = 1'($urandom);
            Branch = 3'($urandom); ALUOp = 4'($urandom); ALUSrc = 2'($urandom);
            PC = $urandom & ~32'd3;
            rs1_data = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 8);
            rs2_data = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 8);
            imm = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40)) - 32'd8;
            rs1_addr = 5'($urandom_range(0, 3)); rs2_addr = 5'($urandom_range(0, 3));
            rd_addr = 5'($urandom_range(0, 3));
            wb_RegWrite = 1'($urandom); wb_rd = 5'($urandom_range(0, 3)); wb_data = $urandom;
            #1; step($sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
